// File: rtl/flash_rd_arb.sv
//------------------------------------------------------------------------------
// Module   : flash_rd_arb
// Brief    : Round-robin read arbiter and fixed-latency read controller placed
//            in front of a parallel flash. Maps PRG and CHR byte requests into
//            their own flash regions, holds a registered address for
//            ACC_CYCLES cycles, then captures the data and acks the requester.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module flash_rd_arb #(
  parameter int unsigned ACC_CYCLES = 4,
  parameter logic [22:0] PRG_BASE   = 23'h000000,
  parameter logic [22:0] CHR_BASE   = 23'h400000
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_prg_req,
  input  logic [21:0] i_prg_addr,
  output logic        o_prg_ack,
  output logic [7:0]  o_prg_data,
  input  logic        i_chr_req,
  input  logic [21:0] i_chr_addr,
  output logic        o_chr_ack,
  output logic [7:0]  o_chr_data,
  output logic [22:0] o_flash_addr,
  input  logic [7:0]  i_flash_q,
  output logic        o_busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  localparam logic       c_port_prg = 1'b0;
  localparam logic       c_port_chr = 1'b1;
  // Counter starts at ACC_CYCLES-1 so ACCESS lasts exactly ACC_CYCLES edges.
  localparam logic [3:0] c_cnt_load = 4'(ACC_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic        r_port;
  logic        r_rr_last;
  logic [22:0] r_flash_addr;
  logic        r_prg_ack;
  logic        r_chr_ack;
  logic [7:0]  r_prg_data;
  logic [7:0]  r_chr_data;

  logic        w_grant;
  logic        w_grant_chr;
  logic        w_conflict;
  logic        w_access_end;
  logic [22:0] w_prg_flash_addr;
  logic [22:0] w_chr_flash_addr;

  // Region mapping; the 23-bit sum drops the carry so addresses wrap.
  assign w_prg_flash_addr = PRG_BASE + {1'b0, i_prg_addr};
  assign w_chr_flash_addr = CHR_BASE + {1'b0, i_chr_addr};

  assign w_conflict   = i_prg_req & i_chr_req;
  assign w_access_end = (r_state == ST_ACCESS) && (r_cnt == 4'd0);

  // State register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and grant decode; arbitration happens only in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_grant_chr = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_prg_req || i_chr_req) begin
          w_grant     = 1'b1;
          // CHR wins when alone, or on a conflict when PRG was served last.
          w_grant_chr = i_chr_req && (!i_prg_req || (r_rr_last == c_port_prg));
          w_state_nxt = ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Address, counter, arbitration history and per-port ack/data registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt        <= 4'd0;
      r_port       <= c_port_prg;
      r_rr_last    <= c_port_prg;
      r_flash_addr <= 23'h0;
      r_prg_ack    <= 1'b0;
      r_chr_ack    <= 1'b0;
      r_prg_data   <= 8'h00;
      r_chr_data   <= 8'h00;
    end else begin
      r_prg_ack <= w_access_end && (r_port == c_port_prg);
      r_chr_ack <= w_access_end && (r_port == c_port_chr);

      if (w_grant) begin
        r_flash_addr <= w_grant_chr ? w_chr_flash_addr : w_prg_flash_addr;
        r_cnt        <= c_cnt_load;
        r_port       <= w_grant_chr;
        // History only moves when a real conflict was resolved.
        if (w_conflict) begin
          r_rr_last <= w_grant_chr;
        end
      end else if ((r_state == ST_ACCESS) && (r_cnt != 4'd0)) begin
        r_cnt <= r_cnt - 4'd1;
      end

      if (w_access_end) begin
        if (r_port == c_port_chr) begin
          r_chr_data <= i_flash_q;
        end else begin
          r_prg_data <= i_flash_q;
        end
      end
    end
  end

  assign o_prg_ack    = r_prg_ack;
  assign o_chr_ack    = r_chr_ack;
  assign o_prg_data   = r_prg_data;
  assign o_chr_data   = r_chr_data;
  assign o_flash_addr = r_flash_addr;
  assign o_busy       = (r_state != ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_flash_rd_arb.sv
//------------------------------------------------------------------------------
// Module   : tb_flash_rd_arb
// Brief    : Scoreboard bench for flash_rd_arb. Two instances: one with default
//            parameters, one with ACC_CYCLES=1 and CHR_BASE=23'h500000.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none
`timescale 1ns/1ps

module tb_flash_rd_arb;

  typedef struct {
    logic        chr;
    logic [22:0] addr;
    logic [7:0]  data;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int vectors     = 0;
  int miscompares = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Instance 0 signals (default parameters)
  logic        rst0_n;
  logic        prg_req0, chr_req0, prg_ack0, chr_ack0, busy0;
  logic [21:0] prg_addr0, chr_addr0;
  logic [7:0]  prg_data0, chr_data0, fq0;
  logic [22:0] faddr0;

  // Instance 1 signals (ACC_CYCLES=1, CHR_BASE=23'h500000)
  logic        rst1_n;
  logic        prg_req1, chr_req1, prg_ack1, chr_ack1, busy1;
  logic [21:0] prg_addr1, chr_addr1;
  logic [7:0]  prg_data1, chr_data1, fq1;
  logic [22:0] faddr1;

  // Flash content model: flash[0x000010] = 0xA5.
  function automatic logic [7:0] fmodel(input logic [22:0] a);
    return a[7:0] ^ a[15:8] ^ {1'b0, a[22:16]} ^ 8'hB5;
  endfunction

  assign fq0 = fmodel(faddr0);
  assign fq1 = fmodel(faddr1);

  flash_rd_arb u_dut0 (
    .i_clk(clk), .i_rst_n(rst0_n),
    .i_prg_req(prg_req0), .i_prg_addr(prg_addr0), .o_prg_ack(prg_ack0), .o_prg_data(prg_data0),
    .i_chr_req(chr_req0), .i_chr_addr(chr_addr0), .o_chr_ack(chr_ack0), .o_chr_data(chr_data0),
    .o_flash_addr(faddr0), .i_flash_q(fq0), .o_busy(busy0)
  );

  flash_rd_arb #(.ACC_CYCLES(1), .PRG_BASE(23'h000000), .CHR_BASE(23'h500000)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst1_n),
    .i_prg_req(prg_req1), .i_prg_addr(prg_addr1), .o_prg_ack(prg_ack1), .o_prg_data(prg_data1),
    .i_chr_req(chr_req1), .i_chr_addr(chr_addr1), .o_chr_ack(chr_ack1), .o_chr_data(chr_data1),
    .o_flash_addr(faddr1), .i_flash_q(fq1), .o_busy(busy1)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int acc(input int d);
    return (d == 0) ? 4 : 1;
  endfunction

  function automatic logic get_ack(input int d, input logic chr);
    if (d == 0) return chr ? chr_ack0 : prg_ack0;
    return chr ? chr_ack1 : prg_ack1;
  endfunction

  task automatic set_req(input int d, input logic chr, input logic v, input logic [21:0] a);
    if (d == 0) begin
      if (chr) begin chr_req0 = v; chr_addr0 = a; end
      else     begin prg_req0 = v; prg_addr0 = a; end
    end else begin
      if (chr) begin chr_req1 = v; chr_addr1 = a; end
      else     begin prg_req1 = v; prg_addr1 = a; end
    end
  endtask

  task automatic push(input int d, input exp_t e);
    if (d == 0) q0.push_back(e);
    else        q1.push_back(e);
  endtask

  // Bounded wait for a port's ack; returns at the negedge where it is seen.
  task automatic wait_ack(input int d, input logic chr);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (get_ack(d, chr)) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL ack_timeout: dut%0d chr=%0d got no ack, required ack within 50 cycles", d, chr);
  endtask

  // Single read from idle: request raised just after an edge, sampled at the next.
  task automatic read1(input int d, input logic chr, input logic [21:0] a,
                       input logic [22:0] exp_addr, input logic [7:0] exp_data);
    exp_t e;
    @(posedge clk);
    #1;
    e.chr  = chr;
    e.addr = exp_addr;
    e.data = exp_data;
    e.cyc  = cyc + 1 + acc(d);
    push(d, e);
    set_req(d, chr, 1'b1, a);
    wait_ack(d, chr);
    set_req(d, chr, 1'b0, a);
  endtask

  task automatic chk_idle(input int d, input string tag);
    if (d == 0) begin
      chk({tag, "_faddr0"}, {9'b0, faddr0}, 32'h0);
      chk({tag, "_acks0"},  {30'b0, prg_ack0, chr_ack0}, 32'h0);
      chk({tag, "_pdata0"}, {24'b0, prg_data0}, 32'h0);
      chk({tag, "_cdata0"}, {24'b0, chr_data0}, 32'h0);
      chk({tag, "_busy0"},  {31'b0, busy0}, 32'h0);
    end else begin
      chk({tag, "_faddr1"}, {9'b0, faddr1}, 32'h0);
      chk({tag, "_acks1"},  {30'b0, prg_ack1, chr_ack1}, 32'h0);
      chk({tag, "_pdata1"}, {24'b0, prg_data1}, 32'h0);
      chk({tag, "_cdata1"}, {24'b0, chr_data1}, 32'h0);
      chk({tag, "_busy1"},  {31'b0, busy1}, 32'h0);
    end
  endtask

  // Monitor: every ack pops the instance's queue and is checked against it.
  task automatic mon(input int d, input logic pa, input logic ca, input logic [22:0] fa,
                     input logic [7:0] pd, input logic [7:0] cd);
    exp_t e;
    if (!(pa || ca)) return;
    chk($sformatf("ack_exclusive%0d", d), {31'b0, pa & ca}, 32'h0);
    if ((d == 0 && q0.size() == 0) || (d == 1 && q1.size() == 0)) begin
      vectors++;
      miscompares++;
      $display("FAIL unexpected_ack: dut%0d prg=%0d chr=%0d, required no ack", d, pa, ca);
      return;
    end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    chk($sformatf("ack_port%0d", d),  {31'b0, ca}, {31'b0, e.chr});
    chk($sformatf("ack_addr%0d", d),  {9'b0, fa}, {9'b0, e.addr});
    chk($sformatf("ack_data%0d", d),  {24'b0, (ca ? cd : pd)}, {24'b0, e.data});
    chk($sformatf("ack_cycle%0d", d), cyc, e.cyc);
  endtask

  always @(negedge clk) begin
    mon(0, prg_ack0, chr_ack0, faddr0, prg_data0, chr_data0);
    mon(1, prg_ack1, chr_ack1, faddr1, prg_data1, chr_data1);
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200us");
    $fatal(1);
  end

  // Directed stimulus
  initial begin
    exp_t e;
    int   c;
    rst0_n = 1'b0; rst1_n = 1'b0;
    set_req(0, 1'b0, 1'b0, 22'h0); set_req(0, 1'b1, 1'b0, 22'h0);
    set_req(1, 1'b0, 1'b0, 22'h0); set_req(1, 1'b1, 1'b0, 22'h0);

    // Reset state, then release with no requests
    repeat (3) @(posedge clk);
    #1;
    chk_idle(0, "rst");
    chk_idle(1, "rst");
    @(negedge clk);
    rst0_n = 1'b1; rst1_n = 1'b1;
    repeat (3) @(negedge clk);
    chk_idle(0, "post_rst");

    // Single PRG read: flash[0x10] = 0xA5
    @(posedge clk);
    #1;
    e.chr = 1'b0; e.addr = 23'h000010; e.data = 8'hA5; e.cyc = cyc + 1 + 4;
    push(0, e);
    set_req(0, 1'b0, 1'b1, 22'h000010);
    @(negedge clk);
    @(negedge clk);
    chk("prg_faddr_from_grant", {9'b0, faddr0}, 32'h10);
    chk("prg_busy_in_access", {31'b0, busy0}, 32'h1);
    wait_ack(0, 1'b0);
    set_req(0, 1'b0, 1'b0, 22'h000010);
    repeat (3) @(negedge clk);
    chk("prg_data_held", {24'b0, prg_data0}, 32'hA5);
    chk("chr_data_untouched", {24'b0, chr_data0}, 32'h0);
    chk("faddr_held_idle", {9'b0, faddr0}, 32'h10);

    // CHR mapping, and wrap with CHR_BASE=0x500000
    read1(0, 1'b1, 22'h0001F0, 23'h4001F0, fmodel(23'h4001F0));
    read1(1, 1'b1, 22'h3FFFFF, 23'h0FFFFF, fmodel(23'h0FFFFF));
    repeat (2) @(negedge clk);
    chk("prg_data_after_chr", {24'b0, prg_data0}, 32'hA5);

    // Mid-simulation reset clears captured data
    @(negedge clk);
    rst0_n = 1'b0;
    #1;
    chk_idle(0, "mid_rst");
    @(negedge clk);
    rst0_n = 1'b1;

    // Round-robin: both held, re-raised after each ack -> CHR, PRG, CHR, PRG
    @(posedge clk);
    #1;
    c = cyc;
    e.chr = 1'b1; e.addr = 23'h400456; e.data = fmodel(23'h400456); e.cyc = c + 5;  push(0, e);
    e.chr = 1'b0; e.addr = 23'h000123; e.data = fmodel(23'h000123); e.cyc = c + 11; push(0, e);
    e.chr = 1'b1; e.addr = 23'h4F0F0F; e.data = fmodel(23'h4F0F0F); e.cyc = c + 17; push(0, e);
    e.chr = 1'b0; e.addr = 23'h3ABCDE; e.data = fmodel(23'h3ABCDE); e.cyc = c + 23; push(0, e);
    fork
      begin
        set_req(0, 1'b1, 1'b1, 22'h000456);
        wait_ack(0, 1'b1);
        set_req(0, 1'b1, 1'b0, 22'h000456);
        @(posedge clk);
        #1;
        set_req(0, 1'b1, 1'b1, 22'h0F0F0F);
        wait_ack(0, 1'b1);
        set_req(0, 1'b1, 1'b0, 22'h0F0F0F);
      end
      begin
        set_req(0, 1'b0, 1'b1, 22'h000123);
        wait_ack(0, 1'b0);
        set_req(0, 1'b0, 1'b0, 22'h000123);
        @(posedge clk);
        #1;
        set_req(0, 1'b0, 1'b1, 22'h3ABCDE);
        wait_ack(0, 1'b0);
        set_req(0, 1'b0, 1'b0, 22'h3ABCDE);
      end
    join

    // Reset two cycles into ACCESS: no ack, address cleared, then normal read
    repeat (2) @(posedge clk);
    #1;
    set_req(0, 1'b0, 1'b1, 22'h000055);
    @(posedge clk);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst0_n = 1'b0;
    #1;
    set_req(0, 1'b0, 1'b0, 22'h000055);
    chk("abort_faddr", {9'b0, faddr0}, 32'h0);
    chk("abort_busy", {31'b0, busy0}, 32'h0);
    repeat (2) @(negedge clk);
    rst0_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("abort_no_ack_pending", {31'b0, busy0}, 32'h0);
    read1(0, 1'b0, 22'h000055, 23'h000055, fmodel(23'h000055));

    // Minimum timing, ACC_CYCLES=1: back-to-back PRG reads every 3 cycles
    read1(1, 1'b0, 22'h000000, 23'h000000, fmodel(23'h000000));
    read1(1, 1'b0, 22'h000001, 23'h000001, fmodel(23'h000001));
    read1(1, 1'b0, 22'h000002, 23'h000002, fmodel(23'h000002));

    repeat (5) @(negedge clk);
    chk("q0_drained", q0.size(), 32'h0);
    chk("q1_drained", q1.size(), 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
